pet_ce_gen: RTL and testbench

Parametrised clock-enable generator for the PET2001 core. It derives `NUM_CH` independent single-cycle enable strobes from the 56 MHz system clock, covering pixel, CPU and tape rates. Each channel has a run-time programmable divisor, a positive-phase and a mid-period (negative-phase) strobe, per-channel freeze, and a global phase-resync. It sits between the PLL/reset logic and every `ce_*` consumer: video mixer, CPU, PET hardware and tape.

---
 rtl/pet_clk_pkg.sv | 20 ++
 rtl/pet_ce_chan.sv | 59 +++++
 rtl/pet_ce_gen.sv | 34 +++
 tb/tb_pet_ce_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_clk_pkg.sv
// Clock-enable divisor constants and channel indices for the PET2001 core
// running from the 56 MHz system clock.
package pet_clk_pkg;

  localparam int CE_NUM_CH   = 5;
  localparam int CE_DIV_W    = 8;

  // Divisors are period-1 at 56 MHz: 14 MHz, 7 MHz, 1 MHz and 500 kHz.
  localparam int CE_DIV_14M  = 3;
  localparam int CE_DIV_7M   = 7;
  localparam int CE_DIV_1M   = 55;
  localparam int CE_DIV_500K = 111;

  localparam int CH_14M      = 0;
  localparam int CH_7M       = 1;
  localparam int CH_1M       = 2;
  localparam int CH_500K     = 3;
  localparam int CH_SPARE    = 4;

endpackage

// File: rtl/pet_ce_chan.sv
// One clock-enable channel: free-running up-counter with a divisor latched
// at terminal count, producing positive-phase and mid-period strobes.
module pet_ce_chan
  import pet_clk_pkg::*;
#(
  parameter int DIV_W = CE_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_in,
  input  logic             stop,
  input  logic             sync,
  output logic             ce_p,
  output logic             ce_n,
  output logic [DIV_W-1:0] div_act
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_ce_p;
  logic             r_ce_n;
  logic             w_term;
  logic [DIV_W:0]   w_mid;

  // Midpoint is formed one bit wider so an all-ones divisor cannot wrap.
  assign w_term = (r_cnt == r_div);
  assign w_mid  = ({1'b0, r_div} + (DIV_W+1)'(1)) >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_ce_p <= 1'b0;
      r_ce_n <= 1'b0;
    end else if (stop) begin
      r_ce_p <= 1'b0;
      r_ce_n <= 1'b0;
    end else if (sync) begin
      r_cnt  <= '0;
      r_div  <= div_in;
      r_ce_p <= 1'b0;
      r_ce_n <= 1'b0;
    end else begin
      r_ce_p <= (r_cnt == '0);
      r_ce_n <= ({1'b0, r_cnt} == w_mid);
      if (w_term) begin
        r_cnt <= '0;
        r_div <= div_in;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign ce_p    = r_ce_p;
  assign ce_n    = r_ce_n;
  assign div_act = r_div;

endmodule

// File: rtl/pet_ce_gen.sv
// Multi-channel clock-enable generator: NUM_CH independent divider channels
// sharing a single phase-resync pulse.
module pet_ce_gen
  import pet_clk_pkg::*;
#(
  parameter int NUM_CH = CE_NUM_CH,
  parameter int DIV_W  = CE_DIV_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       stop_mask,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       ce_p,
  output logic [NUM_CH-1:0]       ce_n,
  output logic [NUM_CH*DIV_W-1:0] div_act
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pet_ce_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .div_in  (div_in[g*DIV_W +: DIV_W]),
      .stop    (stop_mask[g]),
      .sync    (sync),
      .ce_p    (ce_p[g]),
      .ce_n    (ce_n[g]),
      .div_act (div_act[g*DIV_W +: DIV_W])
    );
  end

endmodule

// File: tb/tb_pet_ce_gen.sv
// Self-checking bench for pet_ce_gen: period-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pet_ce_gen;

  localparam int NCH = 5;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*DW-1:0] div_in;
  logic [NCH-1:0]    stop_mask;
  logic              sync;
  logic [NCH-1:0]    ce_p;
  logic [NCH-1:0]    ce_n;
  logic [NCH*DW-1:0] div_act;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 1'b0;

  pet_ce_gen #(.NUM_CH(NCH), .DIV_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_in    (div_in),
    .stop_mask (stop_mask),
    .sync      (sync),
    .ce_p      (ce_p),
    .ce_n      (ce_n),
    .div_act   (div_act)
  );

  always #5 clk = ~clk;

  // Reference: each channel is a position within a period of div+1 clocks.
  int             mPos [NCH];
  int             mPer [NCH];
  logic [NCH-1:0] mP;
  logic [NCH-1:0] mN;
  logic [NCH*DW-1:0] expDiv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        mPos[i] <= 0;
        mPer[i] <= 1;
      end
      mP <= '0;
      mN <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (stop_mask[i]) begin
          mP[i] <= 1'b0;
          mN[i] <= 1'b0;
        end else if (sync) begin
          mPos[i] <= 0;
          mPer[i] <= int'(div_in[i*DW +: DW]) + 1;
          mP[i]   <= 1'b0;
          mN[i]   <= 1'b0;
        end else begin
          mP[i] <= (mPos[i] == 0);
          mN[i] <= (mPos[i] == mPer[i] / 2);
          if (mPos[i] + 1 == mPer[i]) begin
            mPos[i] <= 0;
            mPer[i] <= int'(div_in[i*DW +: DW]) + 1;
          end else begin
            mPos[i] <= mPos[i] + 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && checkEn) begin
      for (int i = 0; i < NCH; i++) expDiv[i*DW +: DW] = DW'(mPer[i] - 1);
      check("model ce_p", 64'(ce_p), 64'(mP));
      check("model ce_n", 64'(ce_n), 64'(mN));
      check("model div_act", 64'(div_act), 64'(expDiv));
    end
  end

  function automatic logic [NCH*DW-1:0] packDiv(input int c0, c1, c2, c3, c4);
    return {DW'(c4), DW'(c3), DW'(c2), DW'(c1), DW'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts edges until the selected strobe is seen; -1 if the budget expires.
  task automatic waitStrobe(input int ch, input bit neg, input int maxC, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxC) begin
      tick();
      n++;
      seen = neg ? ce_n[ch] : ce_p[ch];
    end
    if (!seen) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL waitStrobe timeout: ch %0d neg %0d got none expected within %0d", ch, neg, maxC);
      n = -1;
    end
  endtask

  int n;
  int cntP [4];
  int cntN [4];
  int hits;

  initial begin
    reset     = 1'b1;
    div_in    = packDiv(3, 7, 55, 111, 1);
    stop_mask = '0;
    sync      = 1'b0;
    #3;
    check("reset ce_p", 64'(ce_p), 64'(0));
    check("reset ce_n", 64'(ce_n), 64'(0));
    check("reset div_act", 64'(div_act), 64'(0));
    @(negedge clk);
    reset   = 1'b0;
    checkEn = 1'b1;

    // First edge strobes both phases from the reset state and loads divisors.
    tick();
    check("e1 ce_p", 64'(ce_p), 64'h1f);
    check("e1 ce_n", 64'(ce_n), 64'h1f);
    check("e1 div_act", 64'(div_act), 64'(packDiv(3, 7, 55, 111, 1)));
    for (int c = 0; c < 4; c++) begin
      cntP[c] = 0;
      cntN[c] = 0;
    end
    for (int k = 0; k < 11200; k++) begin
      tick();
      if (k == 0) begin
        check("e2 ce_p", 64'(ce_p), 64'h1f);
        check("e2 ce_n", 64'(ce_n), 64'h00);
      end
      for (int c = 0; c < 4; c++) begin
        cntP[c] += int'(ce_p[c]);
        cntN[c] += int'(ce_n[c]);
      end
    end
    check("count ce_p 14M", 64'(cntP[0]), 64'(2800));
    check("count ce_p 7M", 64'(cntP[1]), 64'(1400));
    check("count ce_p 1M", 64'(cntP[2]), 64'(200));
    check("count ce_p 500K", 64'(cntP[3]), 64'(100));
    check("count ce_n 14M", 64'(cntN[0]), 64'(2800));
    check("count ce_n 7M", 64'(cntN[1]), 64'(1400));
    check("count ce_n 1M", 64'(cntN[2]), 64'(200));
    check("count ce_n 500K", 64'(cntN[3]), 64'(100));

    // Divisor change on ch0 one clock into a period.
    waitStrobe(0, 1'b0, 20, n);
    div_in[7:0] = 8'd5;
    check("div chg before", 64'(div_act[7:0]), 64'(3));
    tick();
    tick();
    check("div chg pre-term", 64'(div_act[7:0]), 64'(3));
    tick();
    check("div chg at term", 64'(div_act[7:0]), 64'(5));
    tick();
    check("div chg old period", 64'(ce_p[0]), 64'(1));
    waitStrobe(0, 1'b0, 20, n);
    check("div chg new period", 64'(n), 64'(6));

    // Freeze ch2 with its count at 10.
    waitStrobe(2, 1'b0, 200, n);
    repeat (9) tick();
    stop_mask[2] = 1'b1;
    hits = 0;
    repeat (30) begin
      tick();
      hits += int'(ce_p[2] | ce_n[2]);
    end
    check("stop no strobes", 64'(hits), 64'(0));
    check("stop div held", 64'(div_act[23:16]), 64'(55));
    stop_mask[2] = 1'b0;
    // Release edge counts 10->11; the terminal edge is the 46th, strobe on the 47th.
    waitStrobe(2, 1'b0, 100, n);
    check("stop resume phase", 64'(n), 64'(47));

    // Sync with ch1 frozen: ch1 keeps its divisor and phase.
    repeat (13) tick();
    stop_mask = 5'b00010;
    div_in    = packDiv(9, 13, 9, 20, 2);
    repeat (3) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync edge ce_p", 64'(ce_p), 64'(0));
    check("sync edge ce_n", 64'(ce_n), 64'(0));
    tick();
    check("sync first ce_p", 64'(ce_p), 64'h1d);
    check("sync stopped div", 64'(div_act[15:8]), 64'(7));
    check("sync running div", 64'(div_act[7:0]), 64'(9));
    stop_mask = '0;
    repeat (40) tick();

    // Extreme divisors: ch3 all-ones, ch4 zero.
    div_in = packDiv(3, 7, 55, 255, 0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    check("max div ce_p", 64'(ce_p[3]), 64'(1));
    waitStrobe(3, 1'b1, 300, n);
    check("max div ce_n offset", 64'(n), 64'(128));
    waitStrobe(3, 1'b0, 300, n);
    check("max div period tail", 64'(n), 64'(128));
    hits = 0;
    repeat (20) begin
      tick();
      hits += int'(ce_p[4] & ce_n[4]);
    end
    check("zero div both strobes", 64'(hits), 64'(20));

    // Async reset between edges, then the start-up sequence again.
    div_in = packDiv(3, 7, 55, 111, 1);
    repeat (5) tick();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async rst ce_p", 64'(ce_p), 64'(0));
    check("async rst ce_n", 64'(ce_n), 64'(0));
    check("async rst div_act", 64'(div_act), 64'(0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    tick();
    check("re e1 ce_p", 64'(ce_p), 64'h1f);
    check("re e1 ce_n", 64'(ce_n), 64'h1f);
    check("re e1 div_act", 64'(div_act), 64'(packDiv(3, 7, 55, 111, 1)));
    tick();
    check("re e2 ce_p", 64'(ce_p), 64'h1f);
    check("re e2 ce_n", 64'(ce_n), 64'h00);
    waitStrobe(0, 1'b0, 10, n);
    check("re 14M period", 64'(n), 64'(4));
    waitStrobe(2, 1'b1, 60, n);
    check("re 1M ce_n offset", 64'(n), 64'(24));
    repeat (300) tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
